// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache between the fetch port and the memory controller.
// Optional ICACHE_FILL_FWD_EN: forward iload as a hit in the fill cycle when the request still matches.
module icache_direct #(
    parameter int  SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state_reg, state_next;
    logic               valid_reg [SETS];
    logic [TAG_W-1:0]   tag_mem   [SETS];
    logic [31:0]        data_mem  [SETS];
    logic [29:0]        miss_addr_reg, miss_addr_next;

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               lookup_hit;
    logic               fill;
    logic               unused_addr_bits;

    assign req_idx          = imemaddr[IDX_W+1:2];
    assign req_tag          = imemaddr[31:IDX_W+2];
    assign fill_idx         = miss_addr_reg[IDX_W-1:0];
    assign fill_tag         = miss_addr_reg[29:IDX_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    // Tag/data are read combinationally so a hit is reported in the request cycle.
    assign lookup_hit = imemREN && valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign iREN       = (state_reg == MISS);
    assign iaddr      = {miss_addr_reg, 2'b00};

    always_comb begin
        state_next     = state_reg;
        miss_addr_next = miss_addr_reg;
        ihit           = 1'b0;
        fill           = 1'b0;
        // Gated by imemREN so the output reads zero while idle after reset.
        imemload       = imemREN ? data_mem[req_idx] : 32'h0;
        case (state_reg)
            IDLE: begin
                if (lookup_hit) begin
                    ihit = 1'b1;
                end else if (imemREN) begin
                    miss_addr_next = imemaddr[31:2];
                    state_next     = MISS;
                end
            end
            MISS: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (!iwait) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
`ifdef ICACHE_FILL_FWD_EN
                if (!iwait && imemREN && (imemaddr[31:2] == miss_addr_reg)) begin
                    ihit     = 1'b1;
                    imemload = iload;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            miss_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    // Flush takes priority over a fill landing in the same cycle.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                valid_reg[gi] <= 1'b0;
            end else if (flush) begin
                valid_reg[gi] <= 1'b0;
            end else if (fill && (fill_idx == IDX_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a lookup-table cache model checked every cycle, plus literal timing checks.
module tb_icache_direct;

`ifdef ICACHE_FILL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        flush = 1'b0;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;

    int errors = 0;
    int checks = 0;

    icache_direct #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h4) return 32'h2401000A;
        return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
    endfunction

    // Model: what the cache holds, and which word (if any) is being fetched from memory.
    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic        m_busy;
    logic [29:0] m_addr;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
            m_busy <= 1'b0;
            m_addr <= '0;
        end else begin
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (!iwait) begin
                    m_valid[m_addr[3:0]] <= 1'b1;
                    m_tag[m_addr[3:0]]   <= m_addr[29:4];
                    m_data[m_addr[3:0]]  <= iload;
                    m_busy <= 1'b0;
                end
            end else if (imemREN && !(m_valid[imemaddr[5:2]] && m_tag[imemaddr[5:2]] == imemaddr[31:6])) begin
                m_busy <= 1'b1;
                m_addr <= imemaddr[31:2];
            end
            if (flush) for (int i = 0; i < 16; i++) m_valid[i] <= 1'b0;
        end
    end

    always @(negedge CLK) begin
        logic        e_hit, e_iren;
        logic [31:0] e_load;
        logic [3:0]  ix;
        ix = imemaddr[5:2];
        if (!m_busy) begin
            e_iren = 1'b0;
            e_hit  = imemREN && m_valid[ix] && (m_tag[ix] == imemaddr[31:6]);
            e_load = m_data[ix];
        end else begin
            e_iren = 1'b1;
            e_hit  = FWD && !iwait && imemREN && (imemaddr[31:2] == m_addr);
            e_load = iload;
        end
        check("ihit", {31'h0, ihit}, {31'h0, e_hit});
        check("iREN", {31'h0, iREN}, {31'h0, e_iren});
        if (e_iren) check("iaddr", iaddr, {m_addr, 2'b00});
        if (e_hit) check("imemload", imemload, e_load);
    end

    logic        obs_hit, obs_iren;
    logic [31:0] obs_load, obs_iaddr;

    task automatic tick();
        @(negedge CLK);
        obs_hit   = ihit;
        obs_iren  = iREN;
        obs_load  = imemload;
        obs_iaddr = iaddr;
        @(posedge CLK);
        #1;
    endtask

    // Request a word until it hits; memory answers after 'lat' busy cycles of iREN.
    task automatic fetch(input logic [31:0] a, input int lat, output int n,
                         output logic [31:0] d, output logic dm);
        logic got;
        got = 1'b0; n = 0; d = 32'h0; dm = 1'b0;
        imemREN = 1'b1; imemaddr = a; iload = mem_val(a);
        for (int k = 0; k < 40 && !got; k++) begin
            iwait = iREN ? (n < lat) : 1'b1;
            tick();
            if (obs_iren) n++;
            if (obs_hit) begin
                got = 1'b1; d = obs_load; dm = obs_iren;
            end
        end
        check("fetch_completes", {31'h0, got}, 32'h1);
        imemREN = 1'b0; iwait = 1'b1;
        $display("fetch 0x%08h lat=%0d: iREN cycles=%0d data=0x%08h hit_in_miss=%0d", a, lat, n, d, dm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [31:0] d;
        logic        dm;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_ihit", {31'h0, ihit}, 32'h0);
        check("rst_iren", {31'h0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_imemload", imemload, 32'h0);
        RST = 1'b0;

        fetch(32'h4, 2, n, d, dm);
        check("cold_iren_cycles", n, 3);
        check("cold_data", d, 32'h2401000A);
        check("cold_fwd_timing", {31'h0, dm}, {31'h0, FWD});

        fetch(32'h4, 2, n, d, dm);
        check("warm_iren_cycles", n, 0);
        check("warm_data", d, 32'h2401000A);

        fetch(32'h44, 1, n, d, dm);
        check("conflict_iren_cycles", n, 2);
        check("conflict_data", d, mem_val(32'h44));
        fetch(32'h4, 0, n, d, dm);
        check("evicted_iren_cycles", n, 1);
        check("evicted_data", d, 32'h2401000A);

        fetch(32'h8, 0, n, d, dm);
        flush = 1'b1; tick(); flush = 1'b0;
        fetch(32'h8, 0, n, d, dm);
        check("post_flush_iren_cycles", n, 1);

        imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1; iload = mem_val(32'h30);
        tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0; imemREN = 1'b0;
        tick();
        check("flush_mid_miss_iren", {31'h0, obs_iren}, 32'h0);
        $display("flush mid-miss: iREN after flush=%0d", obs_iren);
        fetch(32'h30, 0, n, d, dm);
        check("flush_mid_miss_refetch", n, 1);

        fetch(32'h40, 0, n, d, dm);
        imemREN = 1'b1; imemaddr = 32'h50; iwait = 1'b1; iload = mem_val(32'h50);
        tick(); tick();
        check("pre_rst_iren", {31'h0, iREN}, 32'h1);
        imemREN = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("rst_mid_miss_iren", {31'h0, iREN}, 32'h0);
        check("rst_mid_miss_iaddr", iaddr, 32'h0);
        $display("reset mid-miss: iREN=%0d iaddr=0x%08h", iREN, iaddr);
        @(posedge CLK); #1; RST = 1'b0;
        fetch(32'h40, 0, n, d, dm);
        check("rst_lost_hit", n, 1);

        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1; iload = mem_val(32'h10);
        tick(); tick();
        imemaddr = 32'h20;
        tick();
        check("moved_addr_iaddr_held", obs_iaddr, 32'h10);
        iwait = 1'b0;
        tick();
        check("moved_addr_no_hit", {31'h0, obs_hit}, 32'h0);
        $display("addr moved mid-miss: iaddr=0x%08h fill-cycle ihit=%0d", obs_iaddr, obs_hit);
        iwait = 1'b1;
        fetch(32'h20, 0, n, d, dm);
        check("moved_addr_new_miss", n, 1);
        check("moved_addr_new_data", d, mem_val(32'h20));
        fetch(32'h10, 0, n, d, dm);
        check("moved_addr_old_filled", n, 0);
        check("moved_addr_old_data", d, mem_val(32'h10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Sits directly downstream of the datapath fetch port. It consumes imemREN/imemaddr and returns ihit/imemload.
- On a miss it fetches one word from the memory controller over a REN/wait handshake, fills the frame, then serves the hit.
- It is the block that produces the ihit that gates PC advance.

Parameters:
- SETS, 16, number of frames; power of two, at least 2.
- IDX_W, $clog2(SETS), index width (derived).
- TAG_W, 30-IDX_W, tag width (derived).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- flush  input  1  invalidate all frames (driven from halt).
- ihit  output  1  fetch data valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  word-aligned miss address.
- iwait  input  1  memory busy; iload is valid in the cycle iwait=0 while iREN=1.
- iload  input  32  memory read data.

Behaviour:
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Storage per frame: valid bit, TAG_W tag, 32-bit data.
- Reset (asynchronous): all valid=0, state=IDLE, latched miss address=0. Tag and data contents need not be cleared.
- Outputs during and after reset until the next request: ihit=0, iREN=0, iaddr=0, imemload=0.
- States:
  - IDLE: hit = imemREN & valid[index] & (tag match).
    - On hit: ihit=1 combinationally, imemload=data[index], zero-cycle latency, state stays IDLE.
    - On imemREN with no hit: latch {tag,index}, go to MISS. ihit=0 this cycle.
  - MISS: iREN=1, iaddr={latched tag, latched index, 2'b00}.
    - While iwait=1, hold.
    - When iwait=0: write iload, latched tag and valid=1 into the latched frame at the clock edge, then go to IDLE. ihit=0 this cycle unless ICACHE_FILL_FWD_EN is defined.
- Minimum miss penalty with the feature off: imemREN at cycle 0 (miss) → MISS at cycle 1 → iwait=0 at cycle 1 fills → ihit at cycle 2.
- imemaddr changes during MISS: the fill completes to the latched address. The new address is evaluated in IDLE afterward.
- imemREN deasserts during MISS: the fill still completes; no ihit is generated for it.
- imemload when ihit=0: drives data[index] (don't-care for the consumer). ihit is never asserted when imemREN=0.
- flush is synchronous and takes effect at the next edge: all valid=0.
  - In IDLE, the same cycle may still report a hit from pre-flush state.
  - In MISS, the in-flight fill is dropped: valid stays 0, state goes to IDLE, iREN deasserts the next cycle.
  - flush wins over a simultaneous fill.
- Conflict: a fill to an occupied index overwrites its tag and data; there is no replacement choice.
- RST asserted mid-MISS: iREN drops immediately (asynchronous) and no frame is written.

Optional Feature:
- Macro: ICACHE_FILL_FWD_EN.
- Defined: in MISS, the cycle iwait=0 also asserts ihit=1 with imemload=iload, but only if imemREN=1 and imemaddr still matches the latched address. Miss penalty drops by one cycle. The frame is written the same way as without the feature.
- Undefined: ihit is never asserted in MISS; the hit occurs in the following IDLE cycle.

Test Plan:
- Cold miss: RST pulse, imemREN=1, imemaddr=0x00000004, memory returns iload=0x2401000A after 2 iwait cycles → iREN=1 with iaddr=0x00000004 for 3 cycles, then ihit=1 with imemload=0x2401000A one cycle later (same cycle as iwait=0 with FWD).
- Warm hit: re-request 0x00000004 → ihit=1 in the same cycle, iREN stays 0.
- Conflict (SETS=16): fill 0x00000004, then request 0x00000044 (same index, new tag) → miss with iaddr=0x00000044; re-request 0x00000004 → misses again.
- Flush: fill 0x00000008, pulse flush for one cycle, request 0x00000008 → miss with iREN=1.
- Flush mid-miss: flush while iwait=1 → iREN=0 the next cycle, no frame written, a later request to the same address misses.
- Reset mid-miss: assert RST while iREN=1 → iREN=0 immediately, prior hits now miss.
- Address change mid-miss: imemaddr moves from 0x10 to 0x20 during iwait → fill goes to 0x10 (iaddr held at 0x10), then a new miss is issued for 0x20.
